// File: rtl/tpu_pkg.sv
// Shared types and defaults for the A-tile loader.
// A_LOADER_TRANSPOSE_EN adds the FLUSH state used by the column-major build.
package tpu_pkg;

    localparam int unsigned BITS_AB_DEF = 32;
    localparam int unsigned DIM_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef A_LOADER_TRANSPOSE_EN
        ST_FLUSH,
`endif
        ST_DRAIN
    } loader_state_e;

    function automatic int unsigned DRAIN_CYCLES(input int unsigned dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/a_row_packer.sv
// Row buffer, column counter and registered Ain/Arow/WrEn outputs.
// A_LOADER_TRANSPOSE_EN: keeps a full tile and writes rows only while flush_i is high.
module a_row_packer
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = BITS_AB_DEF,
    parameter int unsigned DIM     = DIM_DEF,
    localparam int unsigned RW     = $clog2(DIM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   xfer_i,
    input  logic [BITS_AB-1:0]     data_i,
    input  logic [RW-1:0]          row_i,
`ifdef A_LOADER_TRANSPOSE_EN
    input  logic                   flush_i,
`endif
    output logic                   col_last_o,
    output logic [DIM*BITS_AB-1:0] ain_o,
    output logic [RW-1:0]          arow_o,
    output logic                   wren_o
);

    logic [RW-1:0]          col_q, col_d;
    logic [DIM*BITS_AB-1:0] ain_q, ain_d;
    logic [RW-1:0]          arow_q;
    logic                   wren_q, wren_d;
    logic                   col_last;

    assign col_last   = (col_q == RW'(DIM - 1));
    assign col_last_o = col_last;

`ifdef A_LOADER_TRANSPOSE_EN
    logic [BITS_AB-1:0] tile_q [DIM][DIM];
    logic               col_step;

    assign col_step = xfer_i && (row_i == RW'(DIM - 1));

    always_ff @(posedge clk) begin
        if (xfer_i) tile_q[row_i][col_q] <= data_i;
    end

    always_comb begin
        ain_d = '0;
        for (int unsigned c = 0; c < DIM; c++) ain_d[c*BITS_AB +: BITS_AB] = tile_q[row_i][c];
        wren_d = flush_i;
    end
`else
    logic [BITS_AB-1:0] rowbuf_q [DIM];
    logic               col_step;

    assign col_step = xfer_i;

    always_ff @(posedge clk) begin
        if (xfer_i) rowbuf_q[col_q] <= data_i;
    end

    // The final element bypasses the buffer so the row can be registered on its own transfer.
    always_comb begin
        ain_d = '0;
        for (int unsigned c = 0; c < DIM; c++)
            ain_d[c*BITS_AB +: BITS_AB] = (RW'(c) == col_q) ? data_i : rowbuf_q[c];
        wren_d = xfer_i && col_last;
    end
`endif

    always_comb begin
        col_d = col_q;
        if (clear_i)       col_d = '0;
        else if (col_step) col_d = col_last ? '0 : col_q + RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            ain_q  <= '0;
            arow_q <= '0;
            wren_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            wren_q <= wren_d;
            if (wren_d) begin
                ain_q  <= ain_d;
                arow_q <= row_i;
            end
        end
    end

    assign ain_o  = ain_q;
    assign arow_o = arow_q;
    assign wren_o = wren_q;

endmodule

// File: rtl/a_tile_loader.sv
// Loads one DIM x DIM A tile from an element stream, writes rows, then drains.
// A_LOADER_TRANSPOSE_EN: column-major input, rows written in a FLUSH phase after LOAD.
module a_tile_loader
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = BITS_AB_DEF,
    parameter int unsigned DIM     = DIM_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [BITS_AB-1:0]         in_data,
    output logic                       in_ready,
    output logic [DIM*BITS_AB-1:0]     Ain,
    output logic [$clog2(DIM)-1:0]     Arow,
    output logic                       WrEn,
    output logic                       en,
    output logic                       go,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned RW = $clog2(DIM);
    localparam int unsigned DW = $clog2(2 * DIM);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES(DIM));

    loader_state_e state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          clear, xfer, col_last, row_last, ready;
    logic [RW-1:0] row_inc;
`ifdef A_LOADER_TRANSPOSE_EN
    logic          flush;
`endif

    assign xfer     = in_valid && ready;
    assign row_last = (row_q == RW'(DIM - 1));
    assign row_inc  = row_last ? '0 : row_q + RW'(1);

    // drain_q counts 0..DRAIN_LAST: en while below it, done on reaching it.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        clear   = 1'b0;
        ready   = 1'b0;
        en      = 1'b0;
        go      = 1'b0;
        done    = 1'b0;
`ifdef A_LOADER_TRANSPOSE_EN
        flush   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                    clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                ready = 1'b1;
`ifdef A_LOADER_TRANSPOSE_EN
                if (xfer) begin
                    row_d = row_inc;
                    if (row_last && col_last) state_d = ST_FLUSH;
                end
`else
                if (xfer && col_last) begin
                    row_d = row_inc;
                    if (row_last) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
`endif
            end
`ifdef A_LOADER_TRANSPOSE_EN
            ST_FLUSH: begin
                flush = 1'b1;
                row_d = row_inc;
                if (row_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
`endif
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    en      = 1'b1;
                    go      = (drain_q == '0);
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    assign in_ready = ready;
    assign busy     = (state_q != ST_IDLE);

    a_row_packer #(
        .BITS_AB (BITS_AB),
        .DIM     (DIM)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .xfer_i     (xfer),
        .data_i     (in_data),
        .row_i      (row_q),
`ifdef A_LOADER_TRANSPOSE_EN
        .flush_i    (flush),
`endif
        .col_last_o (col_last),
        .ain_o      (Ain),
        .arow_o     (Arow),
        .wren_o     (WrEn)
    );

endmodule

// File: tb/tb_a_tile_loader.sv
// Self-checking bench for a_tile_loader; tile contents come from an index-mapping model.
module tb_a_tile_loader;

    localparam int DIM = 8;
    localparam int B   = 32;
    localparam int N   = DIM * DIM;
    localparam int W   = DIM * B;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   in_valid = 1'b0;
    logic [B-1:0]           in_data = '0;
    logic                   in_ready;
    logic [W-1:0]           Ain;
    logic [$clog2(DIM)-1:0] Arow;
    logic                   WrEn, en, go, busy, done;

    int total = 0;
    int bad   = 0;
    logic [B-1:0] vals [N];

    a_tile_loader #(.BITS_AB(B), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .Ain(Ain), .Arow(Arow), .WrEn(WrEn), .en(en), .go(go),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected row r of the tile: which stream index feeds (r, c).
    function automatic logic [W-1:0] exp_row(input int r);
        logic [W-1:0] v;
        int k;
        v = '0;
        for (int c = 0; c < DIM; c++) begin
`ifdef A_LOADER_TRANSPOSE_EN
            k = c * DIM + r;
`else
            k = r * DIM + c;
`endif
            v[c*B +: B] = vals[k];
        end
        return v;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wren"}, W'(WrEn), W'(0));
        chk({tag, "_en"}, W'(en), W'(0));
        chk({tag, "_go"}, W'(go), W'(0));
        chk({tag, "_done"}, W'(done), W'(0));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_ready"}, W'(in_ready), W'(0));
    endtask

    // gap < 0 picks a random idle gap per element; noise toggles start/in_valid where they must be ignored.
    task automatic run_tile(input int gap, input bit noise);
        int g;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", W'(busy), W'(1));
        chk("load_ready", W'(in_ready), W'(1));
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            if (noise) start = 1'($urandom_range(0, 1));
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
`ifdef A_LOADER_TRANSPOSE_EN
            chk("load_wren", W'(WrEn), W'(0));
`else
            if (k % DIM == DIM - 1) begin
                chk("row_wren", W'(WrEn), W'(1));
                chk("row_arow", W'(Arow), W'(k / DIM));
                chk("row_ain", Ain, exp_row(k / DIM));
            end else begin
                chk("load_wren", W'(WrEn), W'(0));
            end
`endif
            if (k < N - 1) begin
                chk("load_en", W'(en), W'(0));
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                for (int i = 0; i < g; i++) begin
                    if (noise) start = 1'($urandom_range(0, 1));
                    tick();
                    start = 1'b0;
                    chk("gap_wren", W'(WrEn), W'(0));
                    chk("gap_ready", W'(in_ready), W'(1));
                end
            end
        end
`ifdef A_LOADER_TRANSPOSE_EN
        chk("flush_ready", W'(in_ready), W'(0));
        chk("flush_en", W'(en), W'(0));
        for (int r = 0; r < DIM; r++) begin
            tick();
            chk("flush_wren", W'(WrEn), W'(1));
            chk("flush_arow", W'(Arow), W'(r));
            chk("flush_ain", Ain, exp_row(r));
        end
`endif
        chk("drain1_en", W'(en), W'(1));
        chk("drain1_go", W'(go), W'(1));
        chk("drain1_ready", W'(in_ready), W'(0));
        chk("drain1_done", W'(done), W'(0));
        for (int i = 1; i < 2 * DIM - 1; i++) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            tick();
            chk("drain_en", W'(en), W'(1));
            chk("drain_go", W'(go), W'(0));
            chk("drain_wren", W'(WrEn), W'(0));
            chk("drain_done", W'(done), W'(0));
            chk("drain_busy", W'(busy), W'(1));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("done_pulse", W'(done), W'(1));
        chk("done_en", W'(en), W'(0));
        chk("done_busy", W'(busy), W'(1));
        tick();
        chk_idle_outputs("post");
    endtask

    initial begin
        #1;
        chk_idle_outputs("rst");
        chk("rst_ain", Ain, W'(0));
        chk("rst_arow", W'(Arow), W'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // Stream activity while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
            chk_idle_outputs("idle_valid");
        end
        in_valid = 1'b0;

        for (int k = 0; k < N; k++) vals[k] = B'(k);
        run_tile(0, 1'b0);

        for (int k = 0; k < N; k++) vals[k] = B'(-(k + 1));
        run_tile(2, 1'b0);

        for (int k = 0; k < N; k++) vals[k] = $urandom;
        run_tile(-1, 1'b1);

        // Asynchronous reset in the middle of a load.
        for (int k = 0; k < N; k++) vals[k] = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_ain", Ain, W'(0));
        chk("midrst_arow", W'(Arow), W'(0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) vals[k] = $urandom;
        run_tile(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
